axis_fsb_bridge: RTL
====================

Name: axis_fsb_bridge

Overview:
Parametrised bridge between a wide host-side AXI-Stream pair and the 80-bit valid/ready FSB link.
- TX: unpacks each wide AXIS beat into one FSB packet per valid slot.
- RX: packs FSB packets back into wide beats, with timeout-based flushing of partial beats.
- A runtime loopback mode replaces the hard-wired stream loopback used in bring-up.
- Sits between the host AXIS FIFO (DMA side) and the FSB master/slave ports of the CL.

Parameters:
AXIS_WIDTH, 512, host stream data width in bits; must be a multiple of SLOT_WIDTH.
SLOT_WIDTH, 128, bits per slot; each slot carries one FSB packet, LSB-aligned.
FSB_WIDTH, 80, FSB packet width; multiple of 8 and <= SLOT_WIDTH.
FLUSH_TIMEOUT, 64, idle cycles after which a partial RX beat is emitted; must be >= 1.
CNT_WIDTH, 16, width of the saturating status counters.
Derived: SLOTS = AXIS_WIDTH/SLOT_WIDTH; PKT_BYTES = FSB_WIDTH/8.

Ports:
clk_i  in  1  clock
resetn_i  in  1  reset, asynchronous assert, active-low
loopback_i  in  1  1 = TX slots feed the RX packer; FSB ports idle
s_axis_tvalid  in  1  host TX beat valid
s_axis_tready  out  1  bridge accepts TX beat
s_axis_tdata  in  AXIS_WIDTH  TX data
s_axis_tkeep  in  AXIS_WIDTH/8  TX byte enables
s_axis_tlast  in  1  ignored; FSB has no framing
m_axis_tvalid  out  1  RX beat valid
m_axis_tready  in  1  host accepts RX beat
m_axis_tdata  out  AXIS_WIDTH  RX data
m_axis_tkeep  out  AXIS_WIDTH/8  RX byte enables
m_axis_tlast  out  1  always 1 when m_axis_tvalid
fsb_master_v_o  out  1  packet to FSB valid
fsb_master_data_o  out  FSB_WIDTH  packet to FSB
fsb_master_r_i  in  1  FSB ready
fsb_slave_v_i  in  1  packet from FSB valid
fsb_slave_data_i  in  FSB_WIDTH  packet from FSB
fsb_slave_r_o  out  1  bridge ready for FSB packet
tx_drop_count_o  out  CNT_WIDTH  slots dropped for partial keep; saturating
rx_flush_count_o  out  CNT_WIDTH  partial beats emitted by timeout; saturating

Behaviour:
- Reset (resetn_i low, asynchronous): all valids, readies and counters = 0; holding register, pack buffer and timers cleared. s_axis_tready and fsb_slave_r_o rise the first cycle after release.
- TX slot validity: slot i is valid iff keep bytes [i*SLOT_WIDTH/8 .. +PKT_BYTES-1] are all 1.
  - Slot with some but not all of those bytes set: dropped; tx_drop_count_o += 1.
  - Slot with none of those bytes set: silently skipped.
  - Drop counting happens in the accept cycle.
- TX holding register: one beat plus a SLOTS-bit pending mask.
  - s_axis_tready = mask empty, OR (exactly one pending bit AND that slot handshakes this cycle).
  - Back-to-back beats therefore see no bubble.
- TX emit order: lowest pending slot first. fsb_master_data_o = slot[FSB_WIDTH-1:0], registered. A pending bit clears on v & r. Skipped slots cost no cycles.
- Beat with zero valid slots: accepted, counted as needed, discarded; no FSB traffic.
- Latency: beat accepted in cycle N -> first fsb_master_v_o in cycle N+1.
- RX pack buffer: slot index idx runs 0..SLOTS-1.
  - Each accepted packet is written zero-extended into slot idx; keep bits for its PKT_BYTES bytes are set; idx increments.
- Full beat: the packet filling slot SLOTS-1 commits the buffer to the output register, which asserts m_axis_tvalid in the next cycle. idx returns to 0.
- Timeout:
  - An idle counter runs while 0 < idx and no packet is accepted; it resets on every accept.
  - On reaching FLUSH_TIMEOUT, the partial beat commits with keep covering only filled slots, unused data zero; rx_flush_count_o += 1.
  - Idle counter does not run while idx = 0.
- Output register: single entry, held stable until m_axis_tready.
  - Commit is allowed when the register is empty or drains in the same cycle.
  - fsb_slave_r_o = 0 only when the next packet would complete the beat and commit is not allowed.
  - A pending timeout commit waits for the register; arriving packets keep filling the buffer meanwhile. If the buffer fills first, it commits as a full beat and no flush is counted.
- Simultaneous timeout-expiry and packet accept: the packet wins; no flush.
- Loopback (loopback_i = 1):
  - TX slot stream feeds the RX packer with fsb_master_r_i replaced by internal RX readiness.
  - fsb_master_v_o = 0 and fsb_slave_r_o = 0.
  - loopback_i changes only while both paths are idle; behaviour otherwise undefined.
- Counters saturate at 2^CNT_WIDTH-1; never wrap.

Test Plan:
- Defaults, loopback_i=0: one TX beat with tkeep all-ones, slot i data = 80'hA0+i -> fsb_master_data_o 80'hA0, A1, A2, A3 on 4 consecutive cycles, first at N+1; tx_drop_count_o=0.
- TX tkeep with slot 1 bytes [16..20] only and slot 2 zero -> 2 packets (slots 0, 3); tx_drop_count_o=1; with fsb_master_r_i toggling every other cycle, order and data are unchanged.
- 4 FSB packets 1,2,3,4 -> one m_axis beat, tkeep = 0x03FF repeated per slot, tlast=1, data slot i = i+1; with m_axis_tready held 0, fsb_slave_r_o drops on the 8th packet.
- 2 FSB packets then 64 idle cycles -> beat with tkeep = 0x000...03FF_03FF, rx_flush_count_o=1; a 3rd packet arriving on cycle 64 instead -> no flush.
- loopback_i=1: 8 full TX beats back-to-back -> 8 identical RX beats in order; FSB ports silent; with m_axis_tready always 1, s_axis_tready never drops between beats.
- Assert resetn_i mid-transmission of slot 2 -> all valids and counters 0 immediately, without waiting for a clock edge; after release the next beat starts fresh at slot 0.

Source files
------------

// File: rtl/axis_fsb_bridge.sv
// rtl/axis_fsb_bridge.sv - wide AXI-Stream to 80-bit FSB valid/ready bridge with RX packing and loopback
//
// Purpose:
//   TX: each accepted host beat is split into SLOTS slots. Each slot whose
//   first PKT_BYTES keep bytes are all set becomes one FSB packet. Slots are
//   sent lowest first. A slot with only some of those bytes set is dropped
//   and counted. A slot with none of them set is skipped.
//   RX: FSB packets are packed into wide beats. A partly filled beat is
//   flushed after FLUSH_TIMEOUT idle cycles.
//   Loopback: the TX slot stream feeds the RX packer and the FSB ports stay idle.
//
// Ports:
//   clk_i, resetn_i         clock, asynchronous active-low reset
//   loopback_i              1 = TX slots drive the RX packer internally
//   s_axis_*                host TX stream in (tlast ignored)
//   m_axis_*                host RX stream out (tlast = tvalid)
//   fsb_master_*            packets toward FSB
//   fsb_slave_*             packets from FSB
//   tx_drop_count_o         saturating count of partially-kept TX slots
//   rx_flush_count_o        saturating count of timeout-flushed RX beats

module axis_fsb_bridge #(
  parameter int AXIS_WIDTH    = 512,
  parameter int SLOT_WIDTH    = 128,
  parameter int FSB_WIDTH     = 80,
  parameter int FLUSH_TIMEOUT = 64,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                      clk_i,
  input  logic                      resetn_i,
  input  logic                      loopback_i,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  input  logic [AXIS_WIDTH-1:0]     s_axis_tdata,
  input  logic [AXIS_WIDTH/8-1:0]   s_axis_tkeep,
  input  logic                      s_axis_tlast,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic [AXIS_WIDTH-1:0]     m_axis_tdata,
  output logic [AXIS_WIDTH/8-1:0]   m_axis_tkeep,
  output logic                      m_axis_tlast,
  output logic                      fsb_master_v_o,
  output logic [FSB_WIDTH-1:0]      fsb_master_data_o,
  input  logic                      fsb_master_r_i,
  input  logic                      fsb_slave_v_i,
  input  logic [FSB_WIDTH-1:0]      fsb_slave_data_i,
  output logic                      fsb_slave_r_o,
  output logic [CNT_WIDTH-1:0]      tx_drop_count_o,
  output logic [CNT_WIDTH-1:0]      rx_flush_count_o
);

  localparam int SLOTS      = AXIS_WIDTH / SLOT_WIDTH;
  localparam int SLOT_BYTES = SLOT_WIDTH / 8;
  localparam int PKT_BYTES  = FSB_WIDTH / 8;
  localparam int KEEP_W     = AXIS_WIDTH / 8;
  localparam int IDX_W      = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int IDLE_W     = $clog2(FLUSH_TIMEOUT + 1);
  localparam int PCNT_W     = $clog2(SLOTS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLOTS - 1);

  function automatic logic [IDX_W-1:0] lowest_idx(input logic [SLOTS-1:0] m);
    lowest_idx = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (m[i]) lowest_idx = IDX_W'(i);
    end
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                   input logic [PCNT_W-1:0]    b);
    logic [CNT_WIDTH:0] s;
    s = {1'b0, a} + (CNT_WIDTH+1)'(b);
    sat_add = s[CNT_WIDTH] ? '1 : s[CNT_WIDTH-1:0];
  endfunction

  // Held low through reset so both input readies rise only after release.
  logic run_q;

  // ---------------------------------------------------------------- TX path
  logic [AXIS_WIDTH-1:0] hold_data_q;
  logic [AXIS_WIDTH-1:0] tx_src;
  logic [SLOTS-1:0]      pend_q;
  logic [SLOTS-1:0]      pend_nx;
  logic [SLOTS-1:0]      pend_low;
  logic [SLOTS-1:0]      in_valid;
  logic [SLOTS-1:0]      in_part;
  logic [PCNT_W-1:0]     drop_n;
  logic [FSB_WIDTH-1:0]  tx_data_q;
  logic [FSB_WIDTH-1:0]  tx_data_nx;
  logic [CNT_WIDTH-1:0]  tx_drop_q;
  logic                  tx_v;
  logic                  tx_r;
  logic                  tx_hs;
  logic                  tx_acc;
  logic                  one_pending;
  logic                  rx_ready;

  always_comb begin
    in_valid = '0;
    in_part  = '0;
    drop_n   = '0;
    for (int i = 0; i < SLOTS; i++) begin
      in_valid[i] = &s_axis_tkeep[i*SLOT_BYTES +: PKT_BYTES];
      in_part[i]  = (|s_axis_tkeep[i*SLOT_BYTES +: PKT_BYTES]) & ~in_valid[i];
      drop_n      = drop_n + PCNT_W'(in_part[i]);
    end
  end

  assign tx_v        = |pend_q;
  assign pend_low    = pend_q & (~pend_q + SLOTS'(1));
  assign one_pending = tx_v & ((pend_q & (pend_q - SLOTS'(1))) == '0);
  assign tx_r        = loopback_i ? rx_ready : fsb_master_r_i;
  assign tx_hs       = tx_v & tx_r;
  // Taking a new beat while the last pending slot leaves avoids a bubble.
  assign s_axis_tready = run_q & (~tx_v | (one_pending & tx_hs));
  assign tx_acc        = s_axis_tvalid & s_axis_tready;

  // The packet output is a register. Compute the next mask and pre-select
  // the slot it will present.
  always_comb begin
    pend_nx    = pend_q;
    tx_src     = hold_data_q;
    tx_data_nx = '0;
    if (tx_acc) begin
      pend_nx = in_valid;
      tx_src  = s_axis_tdata;
    end else if (tx_hs) begin
      pend_nx = pend_q & ~pend_low;
    end
    if (|pend_nx) begin
      tx_data_nx = tx_src[lowest_idx(pend_nx)*SLOT_WIDTH +: FSB_WIDTH];
    end
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      run_q       <= 1'b0;
      pend_q      <= '0;
      hold_data_q <= '0;
      tx_data_q   <= '0;
      tx_drop_q   <= '0;
    end else begin
      run_q     <= 1'b1;
      pend_q    <= pend_nx;
      tx_data_q <= tx_data_nx;
      if (tx_acc) begin
        hold_data_q <= s_axis_tdata;
        tx_drop_q   <= sat_add(tx_drop_q, drop_n);
      end
    end
  end

  assign fsb_master_v_o    = tx_v & ~loopback_i;
  assign fsb_master_data_o = tx_data_q;
  assign tx_drop_count_o   = tx_drop_q;

  // ---------------------------------------------------------------- RX path
  logic [IDX_W-1:0]      idx_q;
  logic [IDLE_W-1:0]     idle_q;
  logic [AXIS_WIDTH-1:0] buf_data_q;
  logic [AXIS_WIDTH-1:0] buf_wr_data;
  logic [KEEP_W-1:0]     buf_keep_q;
  logic [KEEP_W-1:0]     buf_wr_keep;
  logic                  out_v_q;
  logic [AXIS_WIDTH-1:0] out_data_q;
  logic [KEEP_W-1:0]     out_keep_q;
  logic [CNT_WIDTH-1:0]  rx_flush_q;
  logic                  rx_in_v;
  logic [FSB_WIDTH-1:0]  rx_in_data;
  logic                  rx_acc;
  logic                  commit_ok;
  logic                  at_last;
  logic                  idle_expired;
  logic                  full_commit;
  logic                  flush_commit;

  assign commit_ok  = ~out_v_q | m_axis_tready;
  assign at_last    = (idx_q == LAST_IDX);
  // Stall only the packet that would complete a beat with nowhere to go.
  assign rx_ready   = run_q & ~(at_last & ~commit_ok);
  assign rx_in_v    = loopback_i ? tx_v : fsb_slave_v_i;
  assign rx_in_data = loopback_i ? tx_data_q : fsb_slave_data_i;
  assign rx_acc     = rx_in_v & rx_ready;
  assign fsb_slave_r_o = rx_ready & ~loopback_i;

  // The idle counter saturates at FLUSH_TIMEOUT. While saturated, the flush
  // waits for the output register. An accepted packet always takes
  // priority over an expiring timer.
  assign idle_expired = (idle_q >= IDLE_W'(FLUSH_TIMEOUT - 1));
  assign full_commit  = rx_acc & at_last;
  assign flush_commit = ~rx_acc & (idx_q != '0) & idle_expired & commit_ok;

  always_comb begin
    buf_wr_data = buf_data_q;
    buf_wr_keep = buf_keep_q;
    for (int i = 0; i < SLOTS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        buf_wr_data[i*SLOT_WIDTH +: SLOT_WIDTH] = SLOT_WIDTH'(rx_in_data);
        for (int j = 0; j < PKT_BYTES; j++) begin
          buf_wr_keep[i*SLOT_BYTES + j] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      idx_q      <= '0;
      idle_q     <= '0;
      buf_data_q <= '0;
      buf_keep_q <= '0;
      out_v_q    <= 1'b0;
      out_data_q <= '0;
      out_keep_q <= '0;
      rx_flush_q <= '0;
    end else begin
      if (full_commit) begin
        out_v_q    <= 1'b1;
        out_data_q <= buf_wr_data;
        out_keep_q <= buf_wr_keep;
        buf_data_q <= '0;
        buf_keep_q <= '0;
        idx_q      <= '0;
      end else if (flush_commit) begin
        out_v_q    <= 1'b1;
        out_data_q <= buf_data_q;
        out_keep_q <= buf_keep_q;
        buf_data_q <= '0;
        buf_keep_q <= '0;
        idx_q      <= '0;
        rx_flush_q <= sat_add(rx_flush_q, PCNT_W'(1));
      end else begin
        if (out_v_q && m_axis_tready) out_v_q <= 1'b0;
        if (rx_acc) begin
          buf_data_q <= buf_wr_data;
          buf_keep_q <= buf_wr_keep;
          idx_q      <= idx_q + IDX_W'(1);
        end
      end

      if (rx_acc || (idx_q == '0) || flush_commit) begin
        idle_q <= '0;
      end else if (idle_q != IDLE_W'(FLUSH_TIMEOUT)) begin
        idle_q <= idle_q + IDLE_W'(1);
      end
    end
  end

  assign m_axis_tvalid    = out_v_q;
  assign m_axis_tdata     = out_data_q;
  assign m_axis_tkeep     = out_keep_q;
  assign m_axis_tlast     = out_v_q;
  assign rx_flush_count_o = rx_flush_q;

  // tlast has no FSB meaning. Keep bytes beyond each packet are don't-care.
  logic unused_inputs;
  assign unused_inputs = ^{s_axis_tlast, s_axis_tkeep};

endmodule
